// File: rtl/red_pkg.sv
// ============================================================================
// red_pkg: shared types and constants for the reduction-datapath lane blocks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package red_pkg;

  localparam int DATA_W = 16;
  localparam int IDX_W  = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic int nlanes(input int lane_w);
    return DATA_W / lane_w;
  endfunction

endpackage : red_pkg

`default_nettype wire

// File: rtl/red_lane_ext.sv
// ============================================================================
// red_lane_ext: selects one LANE_W-bit lane of a 16-bit word and extends it.
// Sign extension when UNPACK_SEXT_EN is defined, zero extension otherwise.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module red_lane_ext
  import red_pkg::*;
#(
  parameter int LANE_W = 8
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [DATA_W-1:0] o_lane
);

  localparam int c_NLANES = nlanes(LANE_W);

  logic [LANE_W-1:0] w_raw;

  always_comb begin
    w_raw = '0;
    for (int k = 0; k < c_NLANES; k++) begin
      if (i_idx == IDX_W'(k)) begin
        w_raw = i_word[k*LANE_W +: LANE_W];
      end
    end
  end

`ifdef UNPACK_SEXT_EN
  assign o_lane = {{(DATA_W-LANE_W){w_raw[LANE_W-1]}}, w_raw};
`else
  assign o_lane = {{(DATA_W-LANE_W){1'b0}}, w_raw};
`endif

endmodule : red_lane_ext

`default_nettype wire

// File: rtl/red_lane_unpacker.sv
// ============================================================================
// red_lane_unpacker: streams the lanes of a 16-bit word out one per handshake.
// Optional macro UNPACK_SEXT_EN selects sign extension of lanes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module red_lane_unpacker #(
  parameter int LANE_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [15:0]               in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               out_lane,
  output logic [red_pkg::IDX_W-1:0] out_idx,
  output logic                      out_last,
  output logic                      busy
);

  import red_pkg::*;

  localparam int                c_NLANES   = nlanes(LANE_W);
  localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(c_NLANES - 1);

  generate
    if (!((LANE_W == 4) || (LANE_W == 8)) || (DATA_W != 16)) begin : g_bad_cfg
      $error("red_lane_unpacker: LANE_W must be 4 or 8 and DATA_W must be 16");
    end
  endgenerate

  state_t            r_state;
  logic [15:0]       r_word;
  logic [IDX_W-1:0]  r_idx;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_in_ready;

  logic [15:0]       w_lane;
  logic              w_last;

  red_lane_ext #(
    .LANE_W (LANE_W)
  ) u_ext (
    .i_word (r_word),
    .i_idx  (r_idx),
    .o_lane (w_lane)
  );

  assign w_last = r_busy && (r_idx == c_LAST_IDX);

  // in_ready is a register so it stays low through reset and rises one
  // cycle after release, instead of being decoded from the IDLE state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_word      <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_word      <= in_data;
            r_idx       <= '0;
            r_state     <= EMIT;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        EMIT: begin
          if (r_out_valid && out_ready) begin
            if (w_last) begin
              r_state     <= IDLE;
              r_idx       <= '0;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_in_ready  <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_idx   = r_idx;
  assign out_last  = w_last;
  assign out_lane  = r_out_valid ? w_lane : 16'h0000;

endmodule : red_lane_unpacker

`default_nettype wire

// File: tb/tb_red_lane_unpacker.sv
// ============================================================================
// tb_red_lane_unpacker: directed checks of the lane unpacker in 8- and 4-bit
// lane configurations. Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_red_lane_unpacker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
  logic        out_last8, busy8;
  logic [15:0] in_data8 = '0, out_lane8;
  logic [1:0]  out_idx8;

  logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
  logic        out_last4, busy4;
  logic [15:0] in_data4 = '0, out_lane4;
  logic [1:0]  out_idx4;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef UNPACK_SEXT_EN
  localparam logic [15:0] E8_HI = 16'hFFF3;
  localparam logic [15:0] E4_2  = 16'hFFFF;
  localparam logic [15:0] E4_3  = 16'hFFF8;
`else
  localparam logic [15:0] E8_HI = 16'h00F3;
  localparam logic [15:0] E4_2  = 16'h000F;
  localparam logic [15:0] E4_3  = 16'h0008;
`endif

  always #5 clk = ~clk;

  red_lane_unpacker #(.LANE_W(8), .DATA_W(16)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_lane(out_lane8), .out_idx(out_idx8), .out_last(out_last8), .busy(busy8)
  );

  red_lane_unpacker #(.LANE_W(4), .DATA_W(16)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_lane(out_lane4), .out_idx(out_idx4), .out_last(out_last4), .busy(busy4)
  );

  // Observed vectors: {valid, busy, in_ready, last, idx, lane}
  wire [21:0] obs8 = {out_valid8, busy8, in_ready8, out_last8, out_idx8, out_lane8};
  wire [21:0] obs4 = {out_valid4, busy4, in_ready4, out_last4, out_idx4, out_lane4};

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (obs8 !== 22'h0) begin
      n_fail++; $display("FAIL reset8: got %h expected %h", obs8, 22'h0);
    end
    n_checks++;
    if (obs4 !== 22'h0) begin
      n_fail++; $display("FAIL reset4: got %h expected %h", obs4, 22'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs8 !== {4'b0010, 2'd0, 16'h0}) begin
      n_fail++; $display("FAIL post_reset8: got %h expected %h", obs8, {4'b0010, 2'd0, 16'h0});
    end
    n_checks++;
    if (obs4 !== {4'b0010, 2'd0, 16'h0}) begin
      n_fail++; $display("FAIL post_reset4: got %h expected %h", obs4, {4'b0010, 2'd0, 16'h0});
    end
  endtask

  task automatic test_lane8();
    in_valid8 = 1'b1; in_data8 = 16'hF37A; out_ready8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0; in_data8 = 16'h0000;
    n_checks++;
    if (obs8 !== {4'b1100, 2'd0, 16'h007A}) begin
      n_fail++; $display("FAIL lane8_idx0: got %h expected %h", obs8, {4'b1100, 2'd0, 16'h007A});
    end
    @(negedge clk);
    n_checks++;
    if (obs8 !== {4'b1101, 2'd1, E8_HI}) begin
      n_fail++; $display("FAIL lane8_idx1: got %h expected %h", obs8, {4'b1101, 2'd1, E8_HI});
    end
    @(negedge clk);
    n_checks++;
    if (obs8 !== {4'b0010, 2'd0, 16'h0}) begin
      n_fail++; $display("FAIL lane8_done: got %h expected %h", obs8, {4'b0010, 2'd0, 16'h0});
    end
  endtask

  task automatic test_lane4();
    logic [15:0] exp4 [4];
    exp4[0] = 16'h0007; exp4[1] = 16'h0001; exp4[2] = E4_2; exp4[3] = E4_3;
    in_valid4 = 1'b1; in_data4 = 16'h8F17; out_ready4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs4 !== {3'b110, (i == 3), 2'(i), exp4[i]}) begin
        n_fail++;
        $display("FAIL lane4_idx%0d: got %h expected %h", i, obs4, {3'b110, (i == 3), 2'(i), exp4[i]});
      end
      @(negedge clk);
    end
    n_checks++;
    if (obs4 !== {4'b0010, 2'd0, 16'h0}) begin
      n_fail++; $display("FAIL lane4_done: got %h expected %h", obs4, {4'b0010, 2'd0, 16'h0});
    end
  endtask

  task automatic test_backpressure();
    in_valid4 = 1'b1; in_data4 = 16'h1234; out_ready4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    n_checks++;
    if (obs4 !== {4'b1100, 2'd0, 16'h0004}) begin
      n_fail++; $display("FAIL bp_idx0: got %h expected %h", obs4, {4'b1100, 2'd0, 16'h0004});
    end
    @(negedge clk);
    out_ready4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs4 !== {4'b1100, 2'd1, 16'h0003}) begin
        n_fail++; $display("FAIL bp_hold%0d: got %h expected %h", i, obs4, {4'b1100, 2'd1, 16'h0003});
      end
      if (i < 3) @(negedge clk);
    end
    out_ready4 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs4 !== {4'b1100, 2'd2, 16'h0002}) begin
      n_fail++; $display("FAIL bp_idx2: got %h expected %h", obs4, {4'b1100, 2'd2, 16'h0002});
    end
    @(negedge clk);
    n_checks++;
    if (obs4 !== {4'b1101, 2'd3, 16'h0001}) begin
      n_fail++; $display("FAIL bp_idx3: got %h expected %h", obs4, {4'b1101, 2'd3, 16'h0001});
    end
    @(negedge clk);
    n_checks++;
    if (obs4 !== {4'b0010, 2'd0, 16'h0}) begin
      n_fail++; $display("FAIL bp_done: got %h expected %h", obs4, {4'b0010, 2'd0, 16'h0});
    end
  endtask

  task automatic test_ignore_in_valid();
    in_valid4 = 1'b1; in_data4 = 16'h5555; out_ready4 = 1'b1;
    @(negedge clk);
    in_data4 = 16'hAAAA;
    for (int i = 0; i < 4; i++) begin
      in_valid4 = (i == 1) || (i == 2);
      n_checks++;
      if (obs4 !== {3'b110, (i == 3), 2'(i), 16'h0005}) begin
        n_fail++;
        $display("FAIL ign_idx%0d: got %h expected %h", i, obs4, {3'b110, (i == 3), 2'(i), 16'h0005});
      end
      @(negedge clk);
    end
    in_valid4 = 1'b0;
    n_checks++;
    if (obs4 !== {4'b0010, 2'd0, 16'h0}) begin
      n_fail++; $display("FAIL ign_done: got %h expected %h", obs4, {4'b0010, 2'd0, 16'h0});
    end
  endtask

  task automatic test_reset_mid();
    in_valid4 = 1'b1; in_data4 = 16'h1234; out_ready4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs4 !== {4'b1100, 2'd1, 16'h0003}) begin
      n_fail++; $display("FAIL rmid_idx1: got %h expected %h", obs4, {4'b1100, 2'd1, 16'h0003});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs4 !== 22'h0) begin
      n_fail++; $display("FAIL rmid_async: got %h expected %h", obs4, 22'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs4 !== {4'b0010, 2'd0, 16'h0}) begin
      n_fail++; $display("FAIL rmid_release: got %h expected %h", obs4, {4'b0010, 2'd0, 16'h0});
    end
    in_valid4 = 1'b1; in_data4 = 16'h4321;
    @(negedge clk);
    in_valid4 = 1'b0;
    n_checks++;
    if (obs4 !== {4'b1100, 2'd0, 16'h0001}) begin
      n_fail++; $display("FAIL rmid_restart: got %h expected %h", obs4, {4'b1100, 2'd0, 16'h0001});
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (obs4 !== {4'b0010, 2'd0, 16'h0}) begin
      n_fail++; $display("FAIL rmid_done: got %h expected %h", obs4, {4'b0010, 2'd0, 16'h0});
    end
  endtask

  initial begin
    test_reset();
    test_lane8();
    test_lane4();
    test_backpressure();
    test_ignore_in_valid();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_red_lane_unpacker

`default_nettype wire

// File: doc/red_lane_unpacker.md
Name: red_lane_unpacker

Overview:
- Splits one 16-bit register word into its LANE_W-bit sub-word lanes and streams them out one per handshake, each extended to 16 bits.
- It is the distribute side of the reduction datapath: it feeds lane operands to serial accumulators and checkers, where the reduction unit collapses lanes into a single sum.
- Sits between register-file read and the multi-cycle lane execution logic.
- Uses valid/ready handshakes on both sides.

Parameters:
- LANE_W, 8, lane width in bits. Legal values: 4 or 8. NLANES = 16/LANE_W (4 or 2).
- DATA_W, 16, word width. Fixed at 16; present for package consistency only.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data holds a word to unpack.
- in_ready  output  1  unpacker can accept a word; high only in IDLE.
- in_data  input  16  word to unpack.
- out_valid  output  1  out_lane is valid.
- out_ready  input  1  downstream accepts out_lane this cycle.
- out_lane  output  16  current lane, extended to 16 bits.
- out_idx  output  2  current lane index, 0 = least-significant lane.
- out_last  output  1  current lane is lane NLANES-1.
- busy  output  1  high in EMIT.

Behaviour:
- Reset: async assert of rst_n forces state IDLE, word register 0, idx 0.
  - Outputs during reset: out_valid 0, out_lane 0, out_idx 0, out_last 0, busy 0, in_ready 0.
  - in_ready rises in the first cycle after rst_n deasserts.
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch in_data, set idx=0, go to EMIT.
  - out_valid rises the next cycle (1-cycle latency).
- EMIT:
  - out_valid=1, busy=1, in_ready=0.
  - out_lane = extend(word[idx*LANE_W +: LANE_W]).
  - out_idx = idx; out_last = (idx == NLANES-1).
- On out_valid&&out_ready:
  - If out_last: return to IDLE.
  - Otherwise: idx increments by 1.
  - idx never wraps past NLANES-1.
- Backpressure: while out_ready=0, out_lane, out_idx and out_last hold stable and out_valid stays high.
- Throughput: NLANES+1 cycles per word minimum (one accept cycle plus one cycle per lane).
- in_valid asserted during EMIT is ignored; the word is not latched and in_data is don't-care.
- out_ready asserted in IDLE has no effect.
- Reset mid-EMIT discards the word. No partial lane is emitted after reset.
- All outputs are registered or decoded from registered state only; there is no combinational in→out path.

Optional Feature:
- Macro UNPACK_SEXT_EN.
  - Defined: lanes are sign-extended; the lane MSB replicates into bits 15:LANE_W.
  - Undefined: lanes are zero-extended; bits 15:LANE_W = 0.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package red_pkg holds:
  - DATA_W = 16;
  - the state enum {IDLE, EMIT};
  - the NLANES constant/function of LANE_W;
  - the lane-index width, 2.
- One combinational sub-module, red_lane_ext: takes word, idx and LANE_W, and returns the selected lane extended to 16 bits (extension per UNPACK_SEXT_EN).
- The FSM, idx counter and handshake logic stay in the top.

Test Plan:
- LANE_W=8, SEXT, in_data=0xF37A, out_ready=1:
  - expect out_lane 0x007A (idx0, last=0), then 0xFFF3 (idx1, last=1);
  - expect in_ready high again in the following cycle.
- Same word without UNPACK_SEXT_EN: expect 0x007A then 0x00F3.
- LANE_W=4, SEXT, in_data=0x8F17: expect 0x0007, 0x0001, 0xFFFF, 0xFFF8 on idx 0..3, with last set only on idx3.
- Backpressure, LANE_W=4, 0x1234: hold out_ready=0 for 3 cycles at idx1 → out_lane stays 0x0003 and out_valid stays 1; then release → 0x0002, 0x0001 follow.
- Pulse in_valid with 0xAAAA during EMIT of 0x5555 → ignored; all lanes emitted are from 0x5555.
- Assert rst_n=0 at idx1 of a 4-lane word → out_valid, busy and in_ready drop immediately. After release, in_ready=1 and the next word starts at idx0.
